third_part: RTL



---
 rtl/third_part_pkg.sv | 109 ++++++++++
 rtl/f36m_cubic.sv | 18 +
 rtl/f36m_mult.sv | 55 +++++
 rtl/third_part.sv | 97 +++++++++
 4 files changed

// File: rtl/third_part_pkg.sv
// Shared widths, FSM encoding and GF(3)/GF(3^M)/GF(3^2M)/GF(3^6M) helpers for the
// final-exponentiation datapath. Trit encoding: 0=00, 1=01, 2=10.
package third_part_pkg;

   localparam int M  = 5;
   localparam int W2 = 2*M - 1;
   localparam int W4 = 4*M - 1;
   localparam int W6 = 12*M - 1;

   typedef enum logic [3:0] {
      CUBE = 4'b0001,
      HOLD = 4'b0010,
      MULT = 4'b0100,
      DONE = 4'b1000
   } state_e;

   function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
      logic [1:0] r;
      if (x == 2'b00 || y == 2'b00) r = 2'b00;
      else if (x == y)              r = 2'b01;
      else                          r = 2'b10;
      return r;
   endfunction

   function automatic logic [W2:0] f3m_add(input logic [W2:0] x, input logic [W2:0] y);
      logic [W2:0] r;
      for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_add(x[2*i +: 2], y[2*i +: 2]);
      return r;
   endfunction

   // Negation in this encoding is a swap of the two bits of every trit.
   function automatic logic [W2:0] f3m_neg(input logic [W2:0] x);
      logic [W2:0] r;
      for (int i = 0; i < M; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
      return r;
   endfunction

   // Field polynomial t^5 + 2t + 1, so t^M folds back as t + 2.
   function automatic logic [W2:0] f3m_mul(input logic [W2:0] x, input logic [W2:0] y);
      logic [2*(2*M-1)-1:0] p;
      p = '0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            p[2*(i+j) +: 2] = gf3_add(p[2*(i+j) +: 2], gf3_mul(x[2*i +: 2], y[2*j +: 2]));
      for (int k = 2*M-2; k >= M; k--) begin
         p[2*(k-M+1) +: 2] = gf3_add(p[2*(k-M+1) +: 2], p[2*k +: 2]);
         p[2*(k-M) +: 2]   = gf3_add(p[2*(k-M) +: 2], gf3_mul(2'b10, p[2*k +: 2]));
      end
      return p[W2:0];
   endfunction

   function automatic logic [W2:0] f3m_cube(input logic [W2:0] x);
      return f3m_mul(f3m_mul(x, x), x);
   endfunction

   // GF(3^2M) = GF(3^M)[s]/(s^2+1), packed {imag, real}.
   function automatic logic [W4:0] f32m_add(input logic [W4:0] u, input logic [W4:0] v);
      return {f3m_add(u[W4:W2+1], v[W4:W2+1]), f3m_add(u[W2:0], v[W2:0])};
   endfunction

   function automatic logic [W4:0] f32m_sub(input logic [W4:0] u, input logic [W4:0] v);
      return {f3m_add(u[W4:W2+1], f3m_neg(v[W4:W2+1])), f3m_add(u[W2:0], f3m_neg(v[W2:0]))};
   endfunction

   function automatic logic [W4:0] f32m_mul(input logic [W4:0] u, input logic [W4:0] v);
      logic [W2:0] re, im;
      re = f3m_add(f3m_mul(u[W2:0], v[W2:0]), f3m_neg(f3m_mul(u[W4:W2+1], v[W4:W2+1])));
      im = f3m_add(f3m_mul(u[W2:0], v[W4:W2+1]), f3m_mul(u[W4:W2+1], v[W2:0]));
      return {im, re};
   endfunction

   function automatic logic [W4:0] f32m_cube(input logic [W4:0] u);
      return {f3m_neg(f3m_cube(u[W4:W2+1])), f3m_cube(u[W2:0])};
   endfunction

   // GF(3^6M) = GF(3^2M)[r]/(r^3 - r - 1), packed {a2, a1, a0}.
   function automatic logic [W6:0] f36m_add(input logic [W6:0] x, input logic [W6:0] y);
      logic [W6:0] r;
      for (int i = 0; i < 3; i++) r[4*M*i +: 4*M] = f32m_add(x[4*M*i +: 4*M], y[4*M*i +: 4*M]);
      return r;
   endfunction

   function automatic logic [W6:0] f36m_scale(input logic [W6:0] x, input logic [W4:0] s);
      logic [W6:0] r;
      for (int i = 0; i < 3; i++) r[4*M*i +: 4*M] = f32m_mul(x[4*M*i +: 4*M], s);
      return r;
   endfunction

   function automatic logic [W6:0] f36m_mul_rho(input logic [W6:0] x);
      return {x[8*M-1:4*M], f32m_add(x[4*M-1:0], x[12*M-1:8*M]), x[12*M-1:8*M]};
   endfunction

   // Cross terms vanish in characteristic 3; r^3 = r+1 and r^6 = r^2+2r+1.
   function automatic logic [W6:0] f36m_cube(input logic [W6:0] x);
      logic [W4:0] c0, c1, c2;
      c0 = f32m_cube(x[4*M-1:0]);
      c1 = f32m_cube(x[8*M-1:4*M]);
      c2 = f32m_cube(x[12*M-1:8*M]);
      return {c2, f32m_sub(c1, c2), f32m_add(f32m_add(c0, c1), c2)};
   endfunction

endpackage

// File: rtl/f36m_cubic.sv
// GF(3^6M) cubing (Frobenius) with a single registered output stage.
module f36m_cubic
   import third_part_pkg::*;
(
   input  logic        clk,
   input  logic [W6:0] a,
   output logic [W6:0] c
);

   logic [W6:0] c_q;

   always_ff @(posedge clk) begin
      c_q <= f36m_cube(a);
   end

   assign c = c_q;

endmodule

// File: rtl/f36m_mult.sv
// GF(3^6M) multiplier: Horner over the r-coefficients of b, one per cycle.
// done rises three cycles after reset and holds until the next reset.
module f36m_mult
   import third_part_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [W6:0] a,
   input  logic [W6:0] b,
   output logic [W6:0] c,
   output logic        done
);

   logic [W6:0] a_q, b_q, acc_q, acc_d;
   logic [1:0]  step_q, step_d;
   logic        done_q, done_d;
   logic [W4:0] bsel;

   always_comb begin
      unique case (step_q)
         2'd0:    bsel = b_q[12*M-1 -: 4*M];
         2'd1:    bsel = b_q[8*M-1 -: 4*M];
         default: bsel = b_q[4*M-1:0];
      endcase
   end

   always_comb begin
      acc_d  = acc_q;
      step_d = step_q;
      done_d = done_q;
      if (!done_q) begin
         acc_d  = f36m_add(f36m_mul_rho(acc_q), f36m_scale(a_q, bsel));
         step_d = step_q + 2'd1;
         if (step_q == 2'd2) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= a;
         b_q    <= b;
         acc_q  <= '0;
         step_q <= 2'd0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         step_q <= step_d;
         done_q <= done_d;
      end
   end

   assign c    = acc_q;
   assign done = done_q;

endmodule

// File: rtl/third_part.sv
// Final exponentiation stage 3: c = a^(3^N_CUBE) * a. A reset pulse starts the run;
// done rises N_CUBE + 6 cycles after the (last) reset cycle. N_CUBE must be >= 1.
module third_part
   import third_part_pkg::*;
#(
   parameter int N_CUBE = M
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [W6:0] a,
   output logic [W6:0] c,
   output logic        done
);

   localparam int CW = $clog2(N_CUBE + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            first_q;
   logic            mreset_q, mreset_d;
   logic            done_q, done_d;
   logic [W6:0]     y_q, y_d;
   logic [W6:0]     c_q, c_d;
   logic [W6:0]     cub_in, cub_o, mprod;
   logic            mdone;

   assign cub_in = first_q ? a : cub_o;

   f36m_cubic u_cubic (
      .clk (clk),
      .a   (cub_in),
      .c   (cub_o)
   );

   f36m_mult u_mult (
      .clk   (clk),
      .reset (mreset_q),
      .a     (a),
      .b     (y_q),
      .c     (mprod),
      .done  (mdone)
   );

   // The multiplier's done is stale on the cycle its reset is applied, hence the mreset mask.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mreset_d = 1'b0;
      done_d   = done_q;
      y_d      = y_q;
      c_d      = c_q;
      unique case (state_q)
         CUBE: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = HOLD;
         end
         HOLD: begin
            y_d      = cub_o;
            mreset_d = 1'b1;
            state_d  = MULT;
         end
         MULT: begin
            if (mdone && !mreset_q) begin
               c_d     = mprod;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: state_d = CUBE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CUBE;
         cnt_q    <= CW'(N_CUBE);
         first_q  <= 1'b1;
         mreset_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         first_q  <= 1'b0;
         mreset_q <= mreset_d;
         done_q   <= done_d;
         y_q      <= y_d;
         c_q      <= c_d;
      end
   end

   assign c    = c_q;
   assign done = done_q;

endmodule
